// File: rtl/cpu_ifetch_pkg.sv
// cpu_ifetch_pkg: shared defaults and the buffered fetch entry
// used by the P1 instruction fetch stage.
package cpu_ifetch_pkg;

  localparam logic [31:0] CPU_RESET_PC = 32'hFFFF_0000;
  localparam int          IFETCH_DEPTH = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/cpu_ifetch_fifo.sv
// cpu_ifetch_fifo: synchronous FIFO of fetch entries with flush;
// push into a full FIFO is taken only alongside a pop.
module cpu_ifetch_fifo
  import cpu_ifetch_pkg::*;
#(
  parameter  int DEPTH = IFETCH_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output logic [CW-1:0] count,
  output fetch_entry_t  head
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q != CW'(DEPTH)) || do_pop);
    if (flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = push_data;
        wr_d        = wr_q + AW'(1);
      end
      if (do_pop) begin
        rd_d = rd_q + AW'(1);
      end
      count_d = count_q + {{AW{1'b0}}, do_push}
                        - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
    mem_q <= mem_d;
  end

  assign count = count_q;
  assign head  = mem_q[rd_q];

endmodule

// File: rtl/cpu_ifetch.sv
// cpu_ifetch: P1 fetch stage, credit-limited requests into an in-order
// buffer; CPU_IFETCH_PERF_EN adds saturating perf counters.
module cpu_ifetch
  import cpu_ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = CPU_RESET_PC,
  parameter int          DEPTH    = IFETCH_DEPTH
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        jump_valid,
  input  logic [31:0] jump_addr,
  output logic        p2_valid,
  output logic [31:0] p2_instr,
  output logic [31:0] p2_pc,
`ifdef CPU_IFETCH_PERF_EN
  output logic [31:0] perf_fetch_empty,
  output logic [31:0] perf_flush,
  output logic [31:0] perf_discard,
`endif
  input  logic        p2_ready
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;

  logic [31:0]   pc_next_q, pc_next_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   used;
  logic [31:0]   jump_tgt;
  logic          accept, rv, drop, push, pop;
  fetch_entry_t  push_data, head;

  assign jump_tgt  = jump_addr & PC_MASK;
  // Buffered plus outstanding words never exceed the FIFO size.
  assign used      = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign imem_req  = !reset && !jump_valid
                  && (used < (CW+1)'(DEPTH));
  assign imem_addr = pc_next_q;
  assign push_data = '{instr: imem_rdata, pc: resp_pc_q};
  assign p2_valid  = fifo_count != '0;
  assign p2_instr  = head.instr;
  assign p2_pc     = head.pc;

  always_comb begin
    accept     = imem_req && imem_ready;
    rv         = imem_rvalid && (inflight_q != '0);
    drop       = rv && (jump_valid || (discard_q != '0));
    push       = rv && !drop;
    pop        = p2_valid && p2_ready;
    pc_next_d  = pc_next_q;
    resp_pc_d  = resp_pc_q;
    discard_d  = discard_q;
    inflight_d = inflight_q + {{(CW-1){1'b0}}, accept}
                            - {{(CW-1){1'b0}}, rv};
    if (jump_valid) begin
      pc_next_d = jump_tgt;
      resp_pc_d = jump_tgt;
      discard_d = inflight_q - {{(CW-1){1'b0}}, rv};
    end else begin
      if (accept) begin
        pc_next_d = pc_next_q + 32'd4;
      end
      if (rv && (discard_q != '0)) begin
        discard_d = discard_q - CW'(1);
      end
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_next_q  <= RESET_PC & PC_MASK;
      resp_pc_q  <= RESET_PC & PC_MASK;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      pc_next_q  <= pc_next_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  cpu_ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (jump_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .count     (fifo_count),
    .head      (head)
  );

  a_rvalid_inflight: assert property (
    @(posedge clock) disable iff (reset)
    !(imem_rvalid && (inflight_q == '0)));

`ifdef CPU_IFETCH_PERF_EN
  logic [31:0] perf_empty_q, perf_empty_d;
  logic [31:0] perf_flush_q, perf_flush_d;
  logic [31:0] perf_disc_q, perf_disc_d;

  always_comb begin
    perf_empty_d = perf_empty_q;
    perf_flush_d = perf_flush_q;
    perf_disc_d  = perf_disc_q;
    if (!p2_valid && (perf_empty_q != '1)) begin
      perf_empty_d = perf_empty_q + 32'd1;
    end
    if (jump_valid && (perf_flush_q != '1)) begin
      perf_flush_d = perf_flush_q + 32'd1;
    end
    if (drop && (perf_disc_q != '1)) begin
      perf_disc_d = perf_disc_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_empty_q <= '0;
      perf_flush_q <= '0;
      perf_disc_q  <= '0;
    end else begin
      perf_empty_q <= perf_empty_d;
      perf_flush_q <= perf_flush_d;
      perf_disc_q  <= perf_disc_d;
    end
  end

  assign perf_fetch_empty = perf_empty_q;
  assign perf_flush       = perf_flush_q;
  assign perf_discard     = perf_disc_q;
`endif

endmodule
